// File: rtl/seq_alu_pkg.sv
// Shared op codes, FSM state type and op classification for the sequential ALU.
package seq_alu_pkg;

  localparam logic [4:0] OP_ADD    = 5'd0;
  localparam logic [4:0] OP_SUB    = 5'd1;
  localparam logic [4:0] OP_SLL    = 5'd2;
  localparam logic [4:0] OP_SRL    = 5'd3;
  localparam logic [4:0] OP_SRA    = 5'd4;
  localparam logic [4:0] OP_XOR    = 5'd5;
  localparam logic [4:0] OP_OR     = 5'd6;
  localparam logic [4:0] OP_AND    = 5'd7;
  localparam logic [4:0] OP_SLT    = 5'd8;
  localparam logic [4:0] OP_SLTU   = 5'd9;
  localparam logic [4:0] OP_MUL    = 5'd10;
  localparam logic [4:0] OP_MULH   = 5'd11;
  localparam logic [4:0] OP_MULHSU = 5'd12;
  localparam logic [4:0] OP_MULHU  = 5'd13;
  localparam logic [4:0] OP_DIV    = 5'd14;
  localparam logic [4:0] OP_DIVU   = 5'd15;
  localparam logic [4:0] OP_REM    = 5'd16;
  localparam logic [4:0] OP_REMU   = 5'd17;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

  function automatic logic is_muldiv(input logic [4:0] op);
    return (op >= OP_MUL) && (op <= OP_REMU);
  endfunction

endpackage

// File: rtl/seq_alu_muldiv_core.sv
// Iterative radix-2 multiply (shift-add) and restoring divide on operand magnitudes,
// with the final sign correction and half/quotient/remainder selection.
module seq_alu_muldiv_core
  import seq_alu_pkg::*;
#(
  parameter  int XLEN = 32,
  localparam int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] result
);

  logic            busy_q;
  logic [SHW-1:0]  cnt_q;
  logic [4:0]      op_q;
  logic            is_div_q;
  logic            neg_res_q;
  logic            neg_rem_q;
  logic [XLEN-1:0] opnd_q;
  logic [XLEN-1:0] acc_q;
  logic [XLEN-1:0] lo_q;

  logic            sgn_a, sgn_b, neg_a, neg_b, is_div;
  logic [XLEN-1:0] mag_a, mag_b;

  always_comb begin
    sgn_a  = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    sgn_b  = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    is_div = (op >= OP_DIV);
    neg_a  = sgn_a && a[XLEN-1];
    neg_b  = sgn_b && b[XLEN-1];
    mag_a  = neg_a ? -a : a;
    mag_b  = neg_b ? -b : b;
  end

  // Multiply: acc:lo is the running product, lo starts as the multiplier.
  // Divide: acc is the partial remainder, lo shifts dividend out and quotient in.
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shift;
  logic [XLEN:0]   div_diff;

  always_comb begin
    mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {acc_q, lo_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else if (start) begin
      busy_q <= 1'b1;
      cnt_q  <= SHW'(XLEN - 1);
    end else if (busy_q) begin
      if (cnt_q == '0) busy_q <= 1'b0;
      else             cnt_q  <= cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      op_q      <= op;
      is_div_q  <= is_div;
      neg_res_q <= neg_a ^ neg_b;
      neg_rem_q <= neg_a;
      opnd_q    <= is_div ? mag_b : mag_a;
      lo_q      <= is_div ? mag_a : mag_b;
      acc_q     <= '0;
    end else if (busy_q) begin
      if (is_div_q) begin
        acc_q <= div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
        lo_q  <= {lo_q[XLEN-2:0], ~div_diff[XLEN]};
      end else begin
        acc_q <= mul_sum[XLEN:1];
        lo_q  <= {mul_sum[0], lo_q[XLEN-1:1]};
      end
    end
  end

  assign done = busy_q && (cnt_q == '0);

  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;

  always_comb begin
    prod     = {acc_q, lo_q};
    prod_fix = neg_res_q ? -prod : prod;
    quo_fix  = neg_res_q ? -lo_q : lo_q;
    rem_fix  = neg_rem_q ? -acc_q : acc_q;
    result   = '0;
    case (op_q)
      OP_MUL:                        result = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  result = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:               result = quo_fix;
      OP_REM, OP_REMU:               result = rem_fix;
      default:                       result = '0;
    endcase
  end

endmodule

// File: rtl/seq_alu.sv
// Handshaked execution unit: single-cycle base ops and M-extension shortcuts,
// iterative multiply/divide through seq_alu_muldiv_core.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter  int XLEN = 32,
  localparam int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            carry,
  output logic            zero
);

  state_e          state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            carry_q, carry_d;
  logic            zero_q, zero_d;
  logic            start;
  logic            core_done;
  logic [XLEN-1:0] core_result;

  logic signed [XLEN-1:0] a_s, b_s;
  logic [SHW-1:0]         shamt;
  logic [XLEN-1:0]        base_res;
  logic                   base_carry;
  logic                   div_zero, div_ovf, shortcut, single;
  logic                   accept;

  assign a_s   = a;
  assign b_s   = b;
  assign shamt = b[SHW-1:0];

  always_comb begin
    div_zero   = (b == '0);
    div_ovf    = (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    base_res   = '0;
    base_carry = 1'b0;
    shortcut   = 1'b0;
    case (op)
      OP_ADD:  {base_carry, base_res} = {1'b0, a} + {1'b0, b};
      OP_SUB:  base_res = a - b;
      OP_SLL:  base_res = a << shamt;
      OP_SRL:  base_res = a >> shamt;
      OP_SRA:  base_res = a_s >>> shamt;
      OP_XOR:  base_res = a ^ b;
      OP_OR:   base_res = a | b;
      OP_AND:  base_res = a & b;
      OP_SLT:  base_res = {{(XLEN-1){1'b0}}, (a_s < b_s)};
      OP_SLTU: base_res = {{(XLEN-1){1'b0}}, (a < b)};
      OP_DIV: begin
        shortcut = div_zero || div_ovf;
        base_res = div_zero ? '1 : a;
      end
      OP_DIVU: begin
        shortcut = div_zero;
        base_res = '1;
      end
      OP_REM: begin
        shortcut = div_zero || div_ovf;
        base_res = div_zero ? a : '0;
      end
      OP_REMU: begin
        shortcut = div_zero;
        base_res = a;
      end
      default: base_res = '0;
    endcase
    single = !is_muldiv(op) || shortcut;
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    start    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          zero_d = (a == b);
          if (single) begin
            result_d = base_res;
            carry_d  = base_carry;
            state_d  = DONE;
          end else begin
            carry_d = 1'b0;
            start   = 1'b1;
            state_d = CALC;
          end
        end
      end
      CALC: if (core_done) state_d = FIX;
      FIX: begin
        result_d = core_result;
        state_d  = DONE;
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
    end
  end

  assign result = result_q;
  assign carry  = carry_q;
  assign zero   = zero_q;

  seq_alu_muldiv_core #(.XLEN(XLEN)) u_core (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .done   (core_done),
    .result (core_result)
  );

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu at XLEN=32 and XLEN=16.
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, carry, zero;
  logic [4:0]  op;
  logic [31:0] a, b, result;

  logic        in_valid16, in_ready16, out_valid16, out_ready16, carry16, zero16;
  logic [4:0]  op16;
  logic [15:0] a16, b16, result16;

  int vec = 0;
  int err = 0;

  always #5 clk = ~clk;

  seq_alu #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry(carry), .zero(zero)
  );

  seq_alu #(.XLEN(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16), .op(op16),
    .a(a16), .b(b16), .out_valid(out_valid16), .out_ready(out_ready16),
    .result(result16), .carry(carry16), .zero(zero16)
  );

  // Drives one op into the 32-bit unit, scrambles inputs after acceptance,
  // measures edges until out_valid and acknowledges the result.
  task automatic issue(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] r, output logic c, output logic z, output int lat);
    int w;
    w = 0;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1; w++;
    end
    if (!in_ready) begin
      vec++; err++;
      $display("FAIL issue_ready: in_ready=%b required 1", in_ready);
    end
    op = o; a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; op = 5'd1; a = ~x; b = ~y;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    if (!out_valid) begin
      vec++; err++;
      $display("FAIL issue_timeout: out_valid=%b after %0d cycles required 1", out_valid, lat);
    end
    r = result; c = carry; z = zero;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    vec++; if (in_ready !== 1'b0) begin err++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    vec++; if (out_valid !== 1'b0) begin err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    vec++; if (result !== 32'h0) begin err++; $display("FAIL reset_result: got %h want 0", result); end
    vec++; if ({carry, zero} !== 2'b00) begin err++; $display("FAIL reset_flags: got %b want 00", {carry, zero}); end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    vec++; if (in_ready !== 1'b1) begin err++; $display("FAIL reset_release_ready: got %b want 1", in_ready); end
    vec++; if (in_ready16 !== 1'b1) begin err++; $display("FAIL reset16_ready: got %b want 1", in_ready16); end
  endtask

  task automatic test_base();
    logic [31:0] r; logic c, z; int lat;
    issue(5'd0, 32'hFFFF_FFFF, 32'h1, r, c, z, lat);
    vec++; if ({c, r} !== 33'h1_0000_0000) begin err++; $display("FAIL add_carry: got %b_%h want 1_00000000", c, r); end
    vec++; if (lat !== 1) begin err++; $display("FAIL add_latency: got %0d want 1", lat); end
    issue(5'd8, 32'hFFFF_FFFF, 32'h1, r, c, z, lat);
    vec++; if (r !== 32'h1) begin err++; $display("FAIL slt: got %h want 1", r); end
    issue(5'd9, 32'hFFFF_FFFF, 32'h1, r, c, z, lat);
    vec++; if (r !== 32'h0) begin err++; $display("FAIL sltu: got %h want 0", r); end
    issue(5'd1, 32'd5, 32'd7, r, c, z, lat);
    vec++; if ({c, r} !== {1'b0, 32'hFFFF_FFFE}) begin err++; $display("FAIL sub: got %b_%h want 0_fffffffe", c, r); end
    issue(5'd0, 32'd5, 32'd5, r, c, z, lat);
    vec++; if ({z, r} !== {1'b1, 32'd10}) begin err++; $display("FAIL add_zero: got %b_%h want 1_0000000a", z, r); end
    issue(5'd5, 32'hF0F0_1234, 32'h0FF0_FFFF, r, c, z, lat);
    vec++; if ({z, r} !== {1'b0, 32'hFF00_EDCB}) begin err++; $display("FAIL xor: got %b_%h want 0_ff00edcb", z, r); end
    issue(5'd20, 32'h1234, 32'h1234, r, c, z, lat);
    vec++; if ({c, z, r} !== {2'b01, 32'h0}) begin err++; $display("FAIL illegal: got %b%b_%h want 01_00000000", c, z, r); end
    vec++; if (lat !== 1) begin err++; $display("FAIL illegal_latency: got %0d want 1", lat); end
  endtask

  task automatic test_shift();
    logic [31:0] r; logic c, z; int lat;
    issue(5'd4, 32'h8000_0000, 32'h0000_0021, r, c, z, lat);
    vec++; if (r !== 32'hC000_0000) begin err++; $display("FAIL sra: got %h want c0000000", r); end
    issue(5'd2, 32'h1, 32'h0000_0024, r, c, z, lat);
    vec++; if (r !== 32'h10) begin err++; $display("FAIL sll: got %h want 00000010", r); end
    issue(5'd3, 32'h8000_0000, 32'd31, r, c, z, lat);
    vec++; if (r !== 32'h1) begin err++; $display("FAIL srl: got %h want 00000001", r); end
  endtask

  task automatic test_mul();
    logic [31:0] r; logic c, z; int lat;
    issue(5'd11, 32'hFFFF_FFFE, 32'd3, r, c, z, lat);
    vec++; if (r !== 32'hFFFF_FFFF) begin err++; $display("FAIL mulh: got %h want ffffffff", r); end
    vec++; if (lat !== 34) begin err++; $display("FAIL mulh_latency: got %0d want 34", lat); end
    issue(5'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, c, z, lat);
    vec++; if ({z, r} !== {1'b1, 32'hFFFF_FFFE}) begin err++; $display("FAIL mulhu: got %b_%h want 1_fffffffe", z, r); end
    issue(5'd10, 32'd7, 32'hFFFF_FFFD, r, c, z, lat);
    vec++; if ({c, r} !== {1'b0, 32'hFFFF_FFEB}) begin err++; $display("FAIL mul: got %b_%h want 0_ffffffeb", c, r); end
    issue(5'd12, 32'hFFFF_FFFF, 32'd2, r, c, z, lat);
    vec++; if (r !== 32'hFFFF_FFFF) begin err++; $display("FAIL mulhsu: got %h want ffffffff", r); end
  endtask

  task automatic test_div();
    logic [31:0] r; logic c, z; int lat;
    issue(5'd14, 32'hFFFF_FFF9, 32'd2, r, c, z, lat);
    vec++; if (r !== 32'hFFFF_FFFD) begin err++; $display("FAIL div: got %h want fffffffd", r); end
    vec++; if (lat !== 34) begin err++; $display("FAIL div_latency: got %0d want 34", lat); end
    issue(5'd16, 32'hFFFF_FFF9, 32'd2, r, c, z, lat);
    vec++; if (r !== 32'hFFFF_FFFF) begin err++; $display("FAIL rem: got %h want ffffffff", r); end
    issue(5'd15, 32'd7, 32'd0, r, c, z, lat);
    vec++; if (r !== 32'hFFFF_FFFF) begin err++; $display("FAIL divu_zero: got %h want ffffffff", r); end
    vec++; if (lat !== 1) begin err++; $display("FAIL divu_zero_latency: got %0d want 1", lat); end
    issue(5'd14, 32'h8000_0000, 32'hFFFF_FFFF, r, c, z, lat);
    vec++; if (r !== 32'h8000_0000) begin err++; $display("FAIL div_ovf: got %h want 80000000", r); end
    vec++; if (lat !== 1) begin err++; $display("FAIL div_ovf_latency: got %0d want 1", lat); end
    issue(5'd16, 32'h8000_0000, 32'hFFFF_FFFF, r, c, z, lat);
    vec++; if (r !== 32'h0) begin err++; $display("FAIL rem_ovf: got %h want 0", r); end
    issue(5'd17, 32'd9, 32'd0, r, c, z, lat);
    vec++; if (r !== 32'd9) begin err++; $display("FAIL remu_zero: got %h want 9", r); end
    issue(5'd15, 32'd100, 32'd7, r, c, z, lat);
    vec++; if (r !== 32'd14) begin err++; $display("FAIL divu: got %h want 0000000e", r); end
    issue(5'd17, 32'd100, 32'd7, r, c, z, lat);
    vec++; if (r !== 32'd2) begin err++; $display("FAIL remu: got %h want 2", r); end
  endtask

  task automatic test_hold();
    op = 5'd0; a = 32'd3; b = 32'd4; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    op = 5'd1; a = 32'd9; b = 32'd1;
    for (int i = 0; i < 5; i++) begin
      vec++;
      if ({out_valid, in_ready, result} !== {2'b10, 32'd7}) begin
        err++;
        $display("FAIL hold_cycle%0d: got v=%b r=%b res=%h want v=1 r=0 res=00000007",
                 i, out_valid, in_ready, result);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    vec++;
    if ({out_valid, in_ready} !== 2'b01) begin
      err++; $display("FAIL hold_release: got v=%b r=%b want v=0 r=1", out_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    op = 5'd0; a = 32'd1; b = 32'd2; in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (i == 5) in_valid = 1'b0;
      vec++;
      if (out_valid !== ((i % 2) == 0)) begin
        err++; $display("FAIL b2b_cycle%0d: out_valid=%b want %b", i, out_valid, (i % 2) == 0);
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_rst_calc();
    logic [31:0] r; logic c, z; int lat; logic seen;
    op = 5'd10; a = 32'd3; b = 32'd5; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    vec++;
    if ({out_valid, in_ready} !== 2'b01) begin
      err++; $display("FAIL rst_calc: got v=%b r=%b want v=0 r=1", out_valid, in_ready);
    end
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    vec++; if (seen !== 1'b0) begin err++; $display("FAIL rst_calc_stale: out_valid seen=%b want 0", seen); end
    issue(5'd0, 32'd2, 32'd2, r, c, z, lat);
    vec++; if (r !== 32'd4) begin err++; $display("FAIL rst_calc_after: got %h want 4", r); end
  endtask

  task automatic test_xlen16();
    int lat;
    op16 = 5'd15; a16 = 16'hFFFF; b16 = 16'h0010; in_valid16 = 1'b1;
    @(posedge clk); #1;
    in_valid16 = 1'b0; a16 = 16'h0; b16 = 16'h0;
    lat = 1;
    while (!out_valid16 && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    vec++; if (result16 !== 16'h0FFF) begin err++; $display("FAIL divu16: got %h want 0fff", result16); end
    vec++; if (lat !== 18) begin err++; $display("FAIL divu16_latency: got %0d want 18", lat); end
    out_ready16 = 1'b1;
    @(posedge clk); #1;
    out_ready16 = 1'b0;
    op16 = 5'd13; a16 = 16'hFFFF; b16 = 16'hFFFF; in_valid16 = 1'b1;
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    lat = 1;
    while (!out_valid16 && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    vec++; if ({zero16, result16} !== {1'b1, 16'hFFFE}) begin err++; $display("FAIL mulhu16: got %b_%h want 1_fffe", zero16, result16); end
    out_ready16 = 1'b1;
    @(posedge clk); #1;
    out_ready16 = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; op = 5'd0; a = 32'h0; b = 32'h0;
    in_valid16 = 1'b0; out_ready16 = 1'b0; op16 = 5'd0; a16 = 16'h0; b16 = 16'h0;
    test_reset();
    test_base();
    test_shift();
    test_mul();
    test_div();
    test_hold();
    test_back_to_back();
    test_rst_calc();
    test_xlen16();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
